// File: rtl/pcm_stream_pkg.sv
// Shared types and helpers for the PCM-to-SPI byte streamer.
//   packer_state_t   : packer FSM states
//   bytes_per_sample : bytes needed to hold one sample of the given width
//   COUNT_W          : width of the saturating event counters
package pcm_stream_pkg;

    localparam int unsigned COUNT_W = 16;

    typedef enum logic [0:0] {IDLE, PACK} packer_state_t;

    function automatic int unsigned bytes_per_sample(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/stream_byte_fifo.sv
// Byte FIFO with registered read data, occupancy output and synchronous flush.
// The FIFO depth must be a power of two and at least 2.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : clears both pointers; a push or pop in the same cycle is dropped
//   push       : write push_data (ignored when full)
//   pop        : read one byte into pop_data on the next edge (ignored when empty)
//   pop_data   : last popped byte, held until the next pop
//   level      : bytes currently stored
//   empty      : no bytes stored
module stream_byte_fifo #(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one wrap bit above the address so full and empty differ.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem [DEPTH];
    logic [7:0]  rdata_q;
    logic        full;
    logic        do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign level   = wr_ptr_q - rd_ptr_q;
    assign pop_data = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
                rdata_q  <= mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pcm_spi_streamer.sv
// Serialises multi-channel PCM frames into bytes, buffers them, and hands one
// byte to the SPI slave per rising edge of its busy flag.
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : accept frames when high
//   flush           : one-cycle clear of FIFO and packer (counters kept)
//   sample_valid    : one-cycle frame strobe
//   sample_data     : frame, channel k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   spi_busy        : SPI slave busy, asynchronous, synchronised here
//   spi_tx_data     : byte for the SPI slave, held between strobes
//   spi_tx_valid    : one-cycle strobe accompanying spi_tx_data
//   fifo_level      : bytes buffered
//   frame_drop      : one-cycle pulse per dropped frame
//   overflow_count  : dropped frames, saturating
//   underrun_count  : IDLE_BYTE substitutions, saturating
module pcm_spi_streamer
    import pcm_stream_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned FIFO_DEPTH   = 4096,
    parameter int unsigned BYTE_ORDER   = 0,
    parameter logic [7:0]  IDLE_BYTE    = 8'h00
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               flush,
    input  logic                               sample_valid,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]   sample_data,
    input  logic                               spi_busy,
    output logic [7:0]                         spi_tx_data,
    output logic                               spi_tx_valid,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic                               frame_drop,
    output logic [COUNT_W-1:0]                 overflow_count,
    output logic [COUNT_W-1:0]                 underrun_count
);

    localparam int unsigned BPS         = bytes_per_sample(SAMPLE_WIDTH);
    localparam int unsigned EXT_W       = BPS * 8;
    localparam int unsigned FRAME_BYTES = CHANNELS * BPS;
    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    packer_state_t                     state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [CHANNELS*SAMPLE_WIDTH-1:0]  frame_q, frame_d;
    logic                              push, drop;
    logic [LVL_W-1:0]                  free_space;

    logic                              busy_s1_q, busy_s2_q, busy_s3_q;
    logic                              busy_rise, pop, fifo_empty;
    logic                              sel_idle_q, tx_valid_q, frame_drop_q;
    logic [7:0]                        fifo_rdata;
    logic [COUNT_W-1:0]                overflow_q, underrun_q;

    logic signed [SAMPLE_WIDTH-1:0]    samp;
    logic [EXT_W-1:0]                  ext;
    logic [7:0]                        frame_bytes [FRAME_BYTES];

    // Latched frame laid out as bytes in transmit order.
    always_comb begin
        samp = '0;
        ext  = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            samp = frame_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            ext  = EXT_W'(samp);
            for (int b = 0; b < int'(BPS); b++) begin
                frame_bytes[k*BPS + b] = (BYTE_ORDER == 0) ? ext[b*8 +: 8]
                                                           : ext[(int'(BPS) - 1 - b)*8 +: 8];
            end
        end
    end

    // Level is exact here because the packer's own writes land before it returns to IDLE.
    assign free_space = LVL_W'(FIFO_DEPTH) - fifo_level;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        push    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_valid && enable) begin
                    if (free_space >= LVL_W'(FRAME_BYTES)) begin
                        frame_d = sample_data;
                        idx_d   = '0;
                        state_d = PACK;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            PACK: begin
                push = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (sample_valid && enable) begin
                    drop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
            push    = 1'b0;
            drop    = 1'b0;
        end
    end

    assign busy_rise = busy_s2_q && !busy_s3_q;
    assign pop       = busy_rise && !fifo_empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            frame_q      <= '0;
            busy_s1_q    <= 1'b0;
            busy_s2_q    <= 1'b0;
            busy_s3_q    <= 1'b0;
            sel_idle_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            overflow_q   <= '0;
            underrun_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            busy_s1_q    <= spi_busy;
            busy_s2_q    <= busy_s1_q;
            busy_s3_q    <= busy_s2_q;
            tx_valid_q   <= busy_rise;
            frame_drop_q <= drop;
            if (busy_rise) begin
                // A request with nothing popped (empty or flushed) serves IDLE_BYTE.
                sel_idle_q <= !pop;
                if (!pop && underrun_q != '1) begin
                    underrun_q <= underrun_q + COUNT_W'(1);
                end
            end
            if (drop && overflow_q != '1) begin
                overflow_q <= overflow_q + COUNT_W'(1);
            end
        end
    end

    stream_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (frame_bytes[idx_q]),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .level     (fifo_level),
        .empty     (fifo_empty)
    );

    assign spi_tx_data    = sel_idle_q ? IDLE_BYTE : fifo_rdata;
    assign spi_tx_valid   = tx_valid_q;
    assign frame_drop     = frame_drop_q;
    assign overflow_count = overflow_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_pcm_spi_streamer.sv
module tb_pcm_spi_streamer;

    logic        clk = 1'b0;
    logic        rst;

    // Instance A: 2 x 16-bit, LSB first, 8-byte FIFO, IDLE_BYTE = A5
    logic        a_en, a_flush, a_valid, a_busy;
    logic [31:0] a_data;
    logic [7:0]  a_tx_data;
    logic        a_tx_valid, a_drop;
    logic [3:0]  a_level;
    logic [15:0] a_ovf, a_unr;

    // Instance B: 1 x 12-bit, MSB first, 4-byte FIFO, IDLE_BYTE = 00
    logic        b_en, b_flush, b_valid, b_busy;
    logic [11:0] b_data;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid, b_drop;
    logic [2:0]  b_level;
    logic [15:0] b_ovf, b_unr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcm_spi_streamer #(
        .SAMPLE_WIDTH (16),
        .CHANNELS     (2),
        .FIFO_DEPTH   (8),
        .BYTE_ORDER   (0),
        .IDLE_BYTE    (8'hA5)
    ) dut_a (
        .clk            (clk),
        .rst            (rst),
        .enable         (a_en),
        .flush          (a_flush),
        .sample_valid   (a_valid),
        .sample_data    (a_data),
        .spi_busy       (a_busy),
        .spi_tx_data    (a_tx_data),
        .spi_tx_valid   (a_tx_valid),
        .fifo_level     (a_level),
        .frame_drop     (a_drop),
        .overflow_count (a_ovf),
        .underrun_count (a_unr)
    );

    pcm_spi_streamer #(
        .SAMPLE_WIDTH (12),
        .CHANNELS     (1),
        .FIFO_DEPTH   (4),
        .BYTE_ORDER   (1),
        .IDLE_BYTE    (8'h00)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .enable         (b_en),
        .flush          (b_flush),
        .sample_valid   (b_valid),
        .sample_data    (b_data),
        .spi_busy       (b_busy),
        .spi_tx_data    (b_tx_data),
        .spi_tx_valid   (b_tx_valid),
        .fifo_level     (b_level),
        .frame_drop     (b_drop),
        .overflow_count (b_ovf),
        .underrun_count (b_unr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One busy pulse: rise seen two edges after busy goes high, byte one edge later.
    task automatic spi_read(input bit sel_b, output logic pre_v, output logic v,
                            output logic [7:0] d);
        if (sel_b) b_busy = 1'b1; else a_busy = 1'b1;
        tick(2);
        pre_v = sel_b ? b_tx_valid : a_tx_valid;
        tick(1);
        v = sel_b ? b_tx_valid : a_tx_valid;
        d = sel_b ? b_tx_data : a_tx_data;
        if (sel_b) b_busy = 1'b0; else a_busy = 1'b0;
        tick(3);
    endtask

    task automatic read_chk(input bit sel_b, input string tag, input logic [7:0] exp);
        logic pv, v;
        logic [7:0] d;
        spi_read(sel_b, pv, v, d);
        chk({tag, "_valid"}, 32'(v), 32'd1);
        chk({tag, "_data"}, 32'(d), 32'(exp));
    endtask

    task automatic send_a(input logic [31:0] frame);
        a_data  = frame;
        a_valid = 1'b1;
        tick(1);
        a_valid = 1'b0;
    endtask

    initial begin
        logic pv, v;
        logic [7:0] d;

        rst = 1'b1;
        a_en = 1'b0; a_flush = 1'b0; a_valid = 1'b0; a_busy = 1'b0; a_data = '0;
        b_en = 1'b1; b_flush = 1'b0; b_valid = 1'b0; b_busy = 1'b0; b_data = '0;
        tick(2);
        chk("rst_level", 32'(a_level), 32'd0);
        chk("rst_txdata", 32'(a_tx_data), 32'd0);
        chk("rst_txvalid", 32'(a_tx_valid), 32'd0);
        chk("rst_drop", 32'(a_drop), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        chk("rst_unr", 32'(a_unr), 32'd0);
        rst = 1'b0;
        tick(1);

        // Frames offered while disabled vanish without being counted.
        send_a(32'h1111_2222);
        chk("dis_drop", 32'(a_drop), 32'd0);
        tick(5);
        chk("dis_level", 32'(a_level), 32'd0);
        chk("dis_ovf", 32'(a_ovf), 32'd0);
        a_en = 1'b1;

        // Basic frame, LSB first.
        send_a(32'hBEEF_1234);
        tick(5);
        chk("f1_level4", 32'(a_level), 32'd4);
        read_chk(1'b0, "f1_b0", 8'h34);
        chk("f1_level3", 32'(a_level), 32'd3);
        read_chk(1'b0, "f1_b1", 8'h12);
        chk("f1_level2", 32'(a_level), 32'd2);
        read_chk(1'b0, "f1_b2", 8'hEF);
        chk("f1_level1", 32'(a_level), 32'd1);
        read_chk(1'b0, "f1_b3", 8'hBE);
        chk("f1_level0", 32'(a_level), 32'd0);

        // Underrun: IDLE_BYTE exactly one cycle after the detected edge.
        spi_read(1'b0, pv, v, d);
        chk("unr_prevalid", 32'(pv), 32'd0);
        chk("unr_valid", 32'(v), 32'd1);
        chk("unr_data", 32'(d), 32'hA5);
        chk("unr_count", 32'(a_unr), 32'd1);
        chk("unr_level", 32'(a_level), 32'd0);

        // Overflow: two frames fill 8 bytes, third is dropped whole.
        send_a(32'h4433_2211);
        tick(5);
        send_a(32'h8877_6655);
        tick(5);
        chk("ovf_level8", 32'(a_level), 32'd8);
        send_a(32'hDEAD_DEAD);
        chk("ovf_drop_pulse", 32'(a_drop), 32'd1);
        chk("ovf_count", 32'(a_ovf), 32'd1);
        tick(1);
        chk("ovf_drop_end", 32'(a_drop), 32'd0);
        chk("ovf_level_kept", 32'(a_level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            read_chk(1'b0, $sformatf("ovf_rd%0d", i), 8'(8'h11 * (i + 1)));
        end
        chk("ovf_drained", 32'(a_level), 32'd0);

        // Pop coinciding with the last packer write at level 3.
        a_data  = 32'hD4C3_B2A1;
        a_valid = 1'b1;
        tick(1);
        a_valid = 1'b0;
        tick(1);
        a_busy = 1'b1;
        tick(2);
        chk("pp_level_before", 32'(a_level), 32'd3);
        tick(1);
        chk("pp_level_after", 32'(a_level), 32'd3);
        chk("pp_valid", 32'(a_tx_valid), 32'd1);
        chk("pp_data", 32'(a_tx_data), 32'hA1);
        a_busy = 1'b0;
        tick(3);
        read_chk(1'b0, "pp_b1", 8'hB2);
        read_chk(1'b0, "pp_b2", 8'hC3);
        read_chk(1'b0, "pp_b3", 8'hD4);

        // 512-byte stream with reads overlapping the packer writes.
        for (int f = 0; f < 128; f++) begin
            send_a({8'(4*f + 3), 8'(4*f + 2), 8'(4*f + 1), 8'(4*f)});
            for (int j = 0; j < 4; j++) begin
                read_chk(1'b0, $sformatf("st%0d", 4*f + j), 8'(4*f + j));
            end
        end
        chk("st_level", 32'(a_level), 32'd0);
        chk("st_unr", 32'(a_unr), 32'd1);

        // Flush mid-PACK, coinciding with a busy edge.
        send_a(32'h5555_5555);
        a_busy = 1'b1;
        tick(2);
        a_flush = 1'b1;
        tick(1);
        a_flush = 1'b0;
        chk("fl_level", 32'(a_level), 32'd0);
        chk("fl_valid", 32'(a_tx_valid), 32'd1);
        chk("fl_data", 32'(a_tx_data), 32'hA5);
        chk("fl_unr", 32'(a_unr), 32'd2);
        a_busy = 1'b0;
        tick(6);
        chk("fl_level_idle", 32'(a_level), 32'd0);
        chk("fl_ovf_kept", 32'(a_ovf), 32'd1);
        send_a(32'hCAFE_F00D);
        tick(5);
        chk("fl_new_level", 32'(a_level), 32'd4);
        read_chk(1'b0, "fl_b0", 8'h0D);
        read_chk(1'b0, "fl_b1", 8'hF0);
        read_chk(1'b0, "fl_b2", 8'hFE);
        read_chk(1'b0, "fl_b3", 8'hCA);
        chk("fl_unr_kept", 32'(a_unr), 32'd2);

        // Asynchronous reset mid-PACK.
        send_a(32'h7777_7777);
        tick(1);
        #2 rst = 1'b1;
        #1;
        chk("ar_level", 32'(a_level), 32'd0);
        chk("ar_ovf", 32'(a_ovf), 32'd0);
        chk("ar_unr", 32'(a_unr), 32'd0);
        chk("ar_txdata", 32'(a_tx_data), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        send_a(32'h0000_0001);
        tick(5);
        chk("ar_new_level", 32'(a_level), 32'd4);

        // Instance B: 12-bit samples sign-extended, MSB first.
        b_data  = 12'h800;
        b_valid = 1'b1;
        tick(1);
        b_valid = 1'b0;
        tick(3);
        chk("b_level2", 32'(b_level), 32'd2);
        read_chk(1'b1, "b_neg_msb", 8'hF8);
        read_chk(1'b1, "b_neg_lsb", 8'h00);
        b_data  = 12'h7AB;
        b_valid = 1'b1;
        tick(1);
        b_valid = 1'b0;
        tick(3);
        read_chk(1'b1, "b_pos_msb", 8'h07);
        read_chk(1'b1, "b_pos_lsb", 8'hAB);
        chk("b_level0", 32'(b_level), 32'd0);
        chk("b_ovf", 32'(b_ovf), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcm_spi_streamer.md
Name: pcm_spi_streamer

Overview:
- Parametrised successor to the single-byte capture-to-SPI path. Takes multi-channel PCM frames from the decimation chain, serialises them into bytes in a configurable order, and buffers them in a byte FIFO.
- Serves one byte per SPI word request with uniform latency. Adds whole-frame atomicity, overflow/underrun accounting, flush and enable control.
- Sits between the PCM producer (CIC/FIR or downsampler) and the SPI slave's data_in/data_in_valid/busy handshake.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel sample (1..32).
- CHANNELS, 2, channels per frame (1..8).
- FIFO_DEPTH, 4096, FIFO capacity in bytes; power of two, at least FRAME_BYTES.
- BYTE_ORDER, 0, 0 = LSB byte of each sample first, 1 = MSB byte first.
- IDLE_BYTE, 8'h00, byte returned on underrun.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  accept frames when 1; frames offered while 0 are ignored and not counted.
- flush  in  1  synchronous one-cycle clear of FIFO and packer.
- sample_valid  in  1  one-cycle frame strobe.
- sample_data  in  CHANNELS*SAMPLE_WIDTH  frame; channel k occupies bits [k*SW +: SW].
- spi_busy  in  1  SPI slave busy; asynchronous to clk-side logic, synchronised internally.
- spi_tx_data  out  8  byte for SPI slave data_in.
- spi_tx_valid  out  1  one-cycle strobe to SPI slave data_in_valid.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently stored.
- frame_drop  out  1  one-cycle pulse when a frame is dropped.
- overflow_count  out  16  dropped frames; saturates at 16'hFFFF.
- underrun_count  out  16  IDLE_BYTE substitutions; saturates at 16'hFFFF.

Behaviour:
- Derived constants:
  - BPS = ceil(SAMPLE_WIDTH/8).
  - FRAME_BYTES = CHANNELS*BPS.
  - Each sample is sign-extended to BPS*8 bits before byte split.
- Reset (rst high, asynchronous): all outputs are 0, FIFO is empty, packer is in IDLE, synchroniser is cleared, counters are 0.
- Packer FSM has two states, IDLE and PACK.
  - IDLE, sample_valid=1, enable=1, free space >= FRAME_BYTES: latch the frame, set byte index to 0, go to PACK.
  - IDLE, sample_valid=1, enable=1, free space < FRAME_BYTES: drop the whole frame, pulse frame_drop, increment overflow_count. Never write partial frames.
  - PACK: write exactly one byte per cycle. Order is channel 0 through CHANNELS-1; within a sample, bytes follow BYTE_ORDER. Return to IDLE on the cycle the last byte is written.
  - sample_valid while in PACK: the new frame is dropped and counted as an overflow.
- Free space is computed at acceptance using the level at that cycle. Concurrent reads only increase space, so the reservation is always safe.
- SPI read path:
  - spi_busy passes through a 2-flop synchroniser plus an edge register.
  - A rising edge detected in cycle N causes a FIFO pop in N if the FIFO is non-empty.
  - spi_tx_data is valid, with a spi_tx_valid pulse, in cycle N+1.
  - If the FIFO is empty at N: spi_tx_data = IDLE_BYTE at N+1 with the same pulse, underrun_count increments, no pop.
  - spi_tx_data holds its value between pulses.
- Simultaneous push and pop in the same cycle is legal: fifo_level is unchanged, and data ordering is preserved including at pointer wrap.
- Full FIFO: no write is ever issued, because the packer reserves space before writing.
- Empty FIFO: no read is ever issued.
- fifo_level is registered and reflects pushes/pops one cycle after they occur.
- flush has priority over everything except rst:
  - pointers and level go to 0, packer returns to IDLE, and an in-progress frame is discarded.
  - counters are kept.
  - a pop in the flush cycle is cancelled; its pending N+1 output becomes IDLE_BYTE, counted as an underrun.
  - sample_valid in the flush cycle is ignored.
- enable deasserted mid-PACK: the current frame completes.
- Counters saturate and never wrap.

Decomposition:
- Package pcm_stream_pkg holds:
  - packer_state_t enum {IDLE, PACK};
  - function bytes_per_sample(width);
  - localparam COUNT_W = 16.
- Sub-module stream_byte_fifo (8-bit, FIFO_DEPTH):
  - registered read, level output, flush input;
  - extra wrap bit on pointers for full/empty detection.
- Packer FSM, synchroniser and counters live in pcm_spi_streamer.

Test Plan:
- SW=16, CH=2, BYTE_ORDER=0; one frame {ch1=16'hBEEF, ch0=16'h1234} -> four busy rising edges return 8'h34, 8'h12, 8'hEF, 8'hBE; fifo_level steps 4→0.
- SW=12, BYTE_ORDER=1; ch0=12'h800 -> sign-extended 16'hF800; bytes 8'hF8 then 8'h00.
- FIFO_DEPTH=8, FRAME_BYTES=4; three frames with no reads -> first two are stored; third gives a frame_drop pulse, overflow_count=1, fifo_level=8.
- Empty FIFO plus one busy rising edge -> spi_tx_data=IDLE_BYTE exactly 1 cycle after the detected edge; underrun_count=1; fifo_level stays 0.
- Busy edge coinciding with a packer write at level 3 -> fifo_level remains 3; byte order is intact across the pointer wrap on a 512-byte continuous stream.
- flush asserted mid-PACK, and separately rst pulsed mid-PACK -> fifo_level=0 and packer back in IDLE; counters are retained after flush and zeroed after rst.
